// File: rtl/axis_pkg.sv
// Shared stream package: FSM state encoding and default widths reused by
// stream blocks (packet generator and future sinks/loopbacks).
package axis_pkg;

  // Stream FSM state encoding shared across stream blocks.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } axis_state_e;

  // Default configuration widths.
  localparam int C_DEF_WIDTH     = 8;
  localparam int C_DEF_LEN_WIDTH = 8;
  localparam int C_DEF_GAP       = 4;

endpackage

// File: rtl/axis_packet_gen_if.sv
// AXI-Stream bus bundle (tdata/tvalid/tready/tlast) with master and slave views.
interface axis_packet_gen_if
  import axis_pkg::*;
#(
  parameter int c_WIDTH = C_DEF_WIDTH
) ();

  logic [c_WIDTH-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_packet_gen.sv
// AXI-Stream packet generator: on start, emits len beats of an incrementing
// pattern from seed, tlast on the final beat, then pulses done.
// Optional build macro AXIS_PKT_GEN_GAP_EN inserts c_GAP idle cycles (busy
// held high) between the last beat and the done pulse.
module axis_packet_gen
  import axis_pkg::*;
#(
  parameter int c_WIDTH     = C_DEF_WIDTH,
  parameter int c_LEN_WIDTH = C_DEF_LEN_WIDTH,
  parameter int c_GAP       = C_DEF_GAP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [c_LEN_WIDTH-1:0] len,
  input  logic [c_WIDTH-1:0]     seed,
  output logic                   busy,
  output logic                   done,
  axis_packet_gen_if.master      m_axis
);

  axis_state_e            state_reg, state_next;
  logic [c_WIDTH-1:0]     tdata_reg, tdata_next;
  logic                   tvalid_reg, tvalid_next;
  logic                   tlast_reg, tlast_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic [c_LEN_WIDTH-1:0] remaining_reg, remaining_next;

`ifdef AXIS_PKT_GEN_GAP_EN
  localparam int GAP_W = (c_GAP > 1) ? $clog2(c_GAP) : 1;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
`else
  // Gap length has no effect in this build; sink it so it does not dangle.
  logic unused_gap_cfg;
  assign unused_gap_cfg = (c_GAP != 0);
`endif

  // Next-state and registered-output logic for the packet FSM.
  always_comb begin
    state_next     = state_reg;
    tdata_next     = tdata_reg;
    tvalid_next    = tvalid_reg;
    tlast_next     = tlast_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    remaining_next = remaining_reg;
`ifdef AXIS_PKT_GEN_GAP_EN
    gap_cnt_next   = gap_cnt_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        // Zero-length requests are dropped silently.
        if (start && (len != '0)) begin
          state_next     = S_SEND;
          remaining_next = len;
          tdata_next     = seed;
          tvalid_next    = 1'b1;
          tlast_next     = (len == c_LEN_WIDTH'(1));
          busy_next      = 1'b1;
        end
      end
      S_SEND: begin
        // Outputs only move on a handshake, so stalls hold tdata/tlast.
        if (tvalid_reg && m_axis.tready) begin
          if (tlast_reg) begin
            tvalid_next    = 1'b0;
            tlast_next     = 1'b0;
            remaining_next = '0;
`ifdef AXIS_PKT_GEN_GAP_EN
            state_next     = S_GAP;
            gap_cnt_next   = GAP_W'(c_GAP - 1);
`else
            state_next     = S_IDLE;
            busy_next      = 1'b0;
            done_next      = 1'b1;
`endif
          end else begin
            tdata_next     = tdata_reg + 1'b1;
            remaining_next = remaining_reg - c_LEN_WIDTH'(1);
            // Two left now means the beat being loaded is the final one.
            tlast_next     = (remaining_reg == c_LEN_WIDTH'(2));
          end
        end
      end
`ifdef AXIS_PKT_GEN_GAP_EN
      S_GAP: begin
        // Counter loads c_GAP-1 so GAP lasts exactly c_GAP cycles.
        if (gap_cnt_reg == '0) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end
      end
`endif
      default: begin
        state_next  = S_IDLE;
        tvalid_next = 1'b0;
        tlast_next  = 1'b0;
        busy_next   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      remaining_reg <= '0;
`ifdef AXIS_PKT_GEN_GAP_EN
      gap_cnt_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      tdata_reg     <= tdata_next;
      tvalid_reg    <= tvalid_next;
      tlast_reg     <= tlast_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      remaining_reg <= remaining_next;
`ifdef AXIS_PKT_GEN_GAP_EN
      gap_cnt_reg   <= gap_cnt_next;
`endif
    end
  end

  assign m_axis.tdata  = tdata_reg;
  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tlast  = tlast_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: doc/axis_packet_gen.md
Name: axis_packet_gen

Overview:
- AXI-Stream master-side packet transmitter: the source end of the stream protocol that the team's slave-side blocks consume.
- On a start command, emits one packet of `len` beats.
- Data is an incrementing pattern beginning at `seed`; `tlast` is asserted on the final beat.
- Used as the stimulus source in front of stream sinks and loopback paths, and as a traffic source for on-chip self-test.

Parameters:
- c_WIDTH, 8, tdata width in bits.
- c_LEN_WIDTH, 8, width of the packet-length input; max packet = 2^c_LEN_WIDTH-1 beats.
- c_GAP, 4, idle cycles inserted after each packet; only used when AXIS_PKT_GEN_GAP_EN is defined; must be >=1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- len  input  c_LEN_WIDTH  packet length in beats, sampled with start.
- seed  input  c_WIDTH  first data word, sampled with start.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  single-cycle pulse on packet completion.
- m_axis_tdata  output  c_WIDTH  beat data.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  final beat of packet.

Behaviour:
- Interface (already decided): single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, state=IDLE, beat counter=0.
- All outputs are registered.
- States: IDLE, SEND, and GAP (GAP only with the macro).
- IDLE:
  - start=1 and len!=0 → latch len into remaining counter and seed into data register; go to SEND.
  - Next cycle: tvalid=1, tdata=seed, tlast=(len==1), busy=1. Start-to-first-valid latency is exactly 1 cycle.
  - start with len==0 → ignored: no beat, no done, stays IDLE.
- SEND:
  - A beat transfers when tvalid && tready.
  - While tvalid=1 and tready=0, tdata and tlast hold stable; tvalid never deasserts without a handshake.
  - Handshake on a non-last beat: tdata <= tdata+1 (wraps modulo 2^c_WIDTH, e.g. 0xFF→0x00); remaining decrements; tlast <= (remaining==2).
  - Back-to-back beats are allowed with tready held high, giving 1 beat/cycle.
  - Handshake on the last beat (tlast=1): tvalid <= 0, tlast <= 0; go to IDLE, or to GAP if enabled.
- done pulses for one cycle in the cycle the block enters IDLE after a packet; busy=0 in that same cycle.
- start is accepted in the cycle done is high, so the minimum inter-packet gap is 1 idle cycle without the macro.
- start while busy → ignored; len/seed changes mid-packet have no effect.
- rst mid-packet:
  - tvalid drops the next cycle; the packet is truncated with no tlast and no done.
  - Block returns to IDLE; this is acceptable only because downstream shares the same reset.
- tready is ignored while tvalid=0.

Optional Feature:
- Macro: AXIS_PKT_GEN_GAP_EN.
- Defined: after the last-beat handshake, the FSM enters GAP for exactly c_GAP cycles.
  - tvalid=0 and busy=1 throughout GAP.
  - Then enters IDLE with the done pulse.
  - start during GAP is ignored.
- Undefined: no GAP state or gap counter is built; c_GAP is unused; last handshake → IDLE directly.

Decomposition:
- Shared package axis_pkg holds:
  - FSM state encoding constants (IDLE=0, SEND=1, GAP=2), reused by future stream blocks.
  - Default width localparams.
- No sub-module is needed; the remaining-beat counter and gap counter are inline. Tight enough to stay in one file, roughly 150 lines.

Test Plan:
- Reset, then start with len=4, seed=0x10, tready=1 → tvalid 1 cycle after start; beats 0x10,0x11,0x12,0x13 on consecutive cycles; tlast only on 0x13; done one cycle after it.
- Same packet with tready toggling 1,0,0,1,... → tdata/tlast held stable through stalls; exactly 4 beats transferred; no beat dropped or duplicated.
- seed=0xFE, len=3 → beats 0xFE,0xFF,0x00; tlast on 0x00.
- len=1 → single beat with tlast=1; len=0 → no tvalid and no done within 10 cycles.
- Assert rst during beat 2 of an 8-beat packet → tvalid=0 next cycle; busy=0; no done; a new start then produces a clean packet.
- start pulsed again while busy → ignored. With AXIS_PKT_GEN_GAP_EN and c_GAP=4: done appears exactly 5 cycles after the last handshake, and a start in the GAP cycles is ignored.
